tqvp_rejunity_vga_scroll: RTL and testbench
===========================================

TQVP_REJUNITY_VGA_SCROLL -- requirements
Module: tqvp_rejunity_vga_scroll

Interface
REQ-001 SHALL have parameter PIXEL_COUNT, default 1024, meaning VRAM pixels (multiple of 32/BPP, max 1024).
REQ-002 SHALL have parameter BPP, default 1, meaning bits per pixel (1 or 2).
REQ-003 SHALL have ports:
- clk  in  1  system clock (64 MHz)
- rst_n  in  1  reset, synchronous, active-low
- ui_in  in  8  unused
- uo_out  out  8  {hsync, color[5:3], vsync, color[2:0]}
- address  in  6  register address
- data_in  in  32  write data
- data_write_n  in  2  11 none, 00 8b, 01 16b, 10 32b
- data_read_n  in  2  11 none, 00 8b, 01 16b, 10 32b
- data_out  out  32  read data
- data_ready  out  1  read data valid / CPU not stalled
- user_interrupt  out  1  sticky interrupt
REQ-004 SHALL have one clock, clk; reset rst_n SHALL be synchronous and active-low.

Function
REQ-005 Timing SHALL be h: 1024 visible, 24 front, 136 sync, 160 back (1344 total); v: 768 visible, 3 front, 6 sync, 29 back (806 total); syncs active-low; counters start at (0,0).
REQ-006 Registers: 0x08 line_cmp[9:0]; 0x10 palette, 4x6 bits at byte lanes 0-3; 0x14 stride[9:0]; 0x18 pix_w-1 [6:0], pix_h-1 [22:16]; 0x1C start[9:0]; 0x20 vram_addr; 0x24 vram_data; 0x38 irq_ack; 0x3C mode: irq_type[1:0], display_en[2].
REQ-007 Only 32-bit writes SHALL affect 0x10-0x24; 8/16/32-bit writes SHALL affect 0x08, 0x38, 0x3C; other writes ignored.
REQ-008 Write 0x24 SHALL store data_in into VRAM word vram_addr, then vram_addr+1, wrapping to 0 after PIXEL_COUNT*BPP/32-1.
REQ-009 Pixel p SHALL be VRAM bits [p*BPP +: BPP]; value indexes palette (BPP=1 uses entries 0,1).
REQ-010 At v=0 row_base and index SHALL load start; each visible pixel advances index after pix_w+1 clocks; each pix_h+1 lines row_base advances by stride; index reloads row_base per line.
REQ-011 Index and row_base arithmetic SHALL wrap modulo PIXEL_COUNT (subtract, not clear).
REQ-012 Color SHALL be palette entry during visible area with display_en=1, else 0; uo_out registered, 1-cycle latency from counters.
REQ-013 irq_type 0: set at v=768 start; 1: set at h=1024 when v==line_cmp; 2: set at h=1024 on last line of each pixel row; 3: never.
REQ-014 user_interrupt SHALL remain high until any write to 0x38; set and ack same cycle: set wins.
REQ-015 Read of any address SHALL return data_out={16'd0, irq, 5'd0, v[9:0]} with data_ready=1 same cycle, except 0x00 stall (REQ-019).
REQ-016 Register/VRAM writes mid-frame SHALL take effect next clock; no shadowing.

Reset
REQ-017 Reset SHALL give: uo_out=0, user_interrupt=0, data_ready=1, counters=0, palette {0x3F,0x00,0x0B,0x10} (entries 3..0), stride=32, pix_w-1=31, pix_h-1=31, start=0, vram_addr=0, line_cmp=0, irq_type=3, display_en=1; VRAM contents undefined.
REQ-018 Reset asserted mid-stall SHALL drop stall; data_ready=1 next cycle.

Configuration
REQ-019 Macro VGA_CPU_STALL_EN: defined -> read of 0x00 holds data_ready=0 until the next h=1024 edge (not current blank), then data_ready=1 for one cycle with normal data; undefined -> 0x00 behaves as REQ-015.

Verification
REQ-020 Reset, BPP=1, write 0x24 with 0x00000001 -> pixel 0 palette[1]=0x0B on uo_out for 32 clocks from h=0, v=0, then 0x10.
REQ-021 vram_addr=PIXEL_COUNT/32-1, two 0x24 writes -> second lands in word 0.
REQ-022 start=1000, PIXEL_COUNT=1024, stride=32 -> second pixel row begins index 8 (wrap).
REQ-023 irq_type=1, line_cmp=100 -> user_interrupt rises at v=100,h=1024 (+1 clk); write 0x38 clears it.
REQ-024 VGA_CPU_STALL_EN, read 0x00 at h=1030 -> data_ready low until next line h=1024 (1338 clk later).
REQ-025 display_en=0 -> color bits 0, syncs still toggle per REQ-005.

Source files
------------

// File: rtl/tqvp_rejunity_vga_scroll.sv
// 1024x768 VGA scroller: a small VRAM is drawn through a 4-entry palette with a scrolled, scaled window.
// Define VGA_CPU_STALL_EN to make reads of address 0x00 stall the CPU until the next h=1024 edge.
module tqvp_rejunity_vga_scroll #(
   parameter int PIXEL_COUNT = 1024,
   parameter int BPP         = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   localparam int WORDS = PIXEL_COUNT * BPP / 32;
   localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [10:0] H_VIS   = 11'd1024;
   localparam logic [10:0] H_SYNC0 = 11'd1048;
   localparam logic [10:0] H_SYNC1 = 11'd1184;
   localparam logic [10:0] H_LAST  = 11'd1343;
   localparam logic [9:0]  V_VIS   = 10'd768;
   localparam logic [9:0]  V_SYNC0 = 10'd771;
   localparam logic [9:0]  V_SYNC1 = 10'd777;
   localparam logic [9:0]  V_LAST  = 10'd805;

   logic [10:0] h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic [9:0]  index_q, index_d, row_base_q, row_base_d, base_cur;
   logic [6:0]  px_cnt_q, px_cnt_d, py_cnt_q, py_cnt_d;
   logic [9:0]  line_cmp_q, stride_q, start_q;
   logic [6:0]  pix_w_q, pix_h_q;
   logic [5:0]  pal_q [4];
   logic [WAW-1:0] vram_addr_q;
   logic [31:0] vram_q [WORDS];
   logic [1:0]  irq_type_q;
   logic        display_en_q, irq_q, irq_d, irq_set;
   logic [7:0]  uo_q, uo_d;
   logic        wr_any, wr32, irq_ack, visible, hsync, vsync;
   logic [10:0] bit_addr;
   logic [31:0] word;
   logic [1:0]  pix_val;
   logic [5:0]  color;

   // Sums never exceed two laps as long as stride stays below PIXEL_COUNT.
   function automatic logic [9:0] wrap_add(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 11'(PIXEL_COUNT)) s = s - 11'(PIXEL_COUNT);
      return s[9:0];
   endfunction

   assign wr_any  = (data_write_n != 2'b11);
   assign wr32    = (data_write_n == 2'b10);
   assign irq_ack = wr_any && (address == 6'h38);
   assign visible = (h_q < H_VIS) && (v_q < V_VIS);
   assign hsync   = !((h_q >= H_SYNC0) && (h_q < H_SYNC1));
   assign vsync   = !((v_q >= V_SYNC0) && (v_q < V_SYNC1));

   always_comb begin
      h_d        = h_q + 11'd1;
      v_d        = v_q;
      px_cnt_d   = px_cnt_q;
      py_cnt_d   = py_cnt_q;
      index_d    = index_q;
      row_base_d = row_base_q;
      base_cur   = (v_q == 10'd0) ? start_q : row_base_q;
      if (h_q == H_LAST) begin
         h_d      = 11'd0;
         px_cnt_d = 7'd0;
         if (v_q == V_LAST) begin
            v_d        = 10'd0;
            py_cnt_d   = 7'd0;
            row_base_d = start_q;
            index_d    = start_q;
         end else begin
            v_d = v_q + 10'd1;
            if (v_q < V_VIS) begin
               if (py_cnt_q >= pix_h_q) begin
                  py_cnt_d   = 7'd0;
                  row_base_d = wrap_add(base_cur, stride_q);
               end else begin
                  py_cnt_d   = py_cnt_q + 7'd1;
                  row_base_d = base_cur;
               end
            end
            index_d = row_base_d;
         end
      end else if (visible) begin
         if (px_cnt_q >= pix_w_q) begin
            px_cnt_d = 7'd0;
            index_d  = wrap_add(index_q, 10'd1);
         end else begin
            px_cnt_d = px_cnt_q + 7'd1;
         end
      end
   end

   always_comb begin
      bit_addr = (BPP == 2) ? {index_q, 1'b0} : {1'b0, index_q};
      word     = vram_q[bit_addr[WAW+4:5]];
      pix_val  = 2'd0;
      if (BPP == 2) pix_val = word[bit_addr[4:0] +: 2];
      else          pix_val = {1'b0, word[bit_addr[4:0]]};
      color = (visible && display_en_q) ? pal_q[pix_val] : 6'd0;
      uo_d  = {hsync, color[5:3], vsync, color[2:0]};
   end

   always_comb begin
      irq_set = 1'b0;
      case (irq_type_q)
         2'd0:    irq_set = (h_q == 11'd0) && (v_q == V_VIS);
         2'd1:    irq_set = (h_q == H_VIS) && (v_q == line_cmp_q);
         2'd2:    irq_set = (h_q == H_VIS) && (v_q < V_VIS) && (py_cnt_q >= pix_h_q);
         default: irq_set = 1'b0;
      endcase
      irq_d = irq_set | (irq_q & ~irq_ack);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_q          <= '0;
         v_q          <= '0;
         index_q      <= '0;
         row_base_q   <= '0;
         px_cnt_q     <= '0;
         py_cnt_q     <= '0;
         irq_q        <= 1'b0;
         uo_q         <= '0;
         line_cmp_q   <= '0;
         stride_q     <= 10'd32;
         start_q      <= '0;
         pix_w_q      <= 7'd31;
         pix_h_q      <= 7'd31;
         pal_q[0]     <= 6'h10;
         pal_q[1]     <= 6'h0B;
         pal_q[2]     <= 6'h00;
         pal_q[3]     <= 6'h3F;
         vram_addr_q  <= '0;
         irq_type_q   <= 2'd3;
         display_en_q <= 1'b1;
      end else begin
         h_q        <= h_d;
         v_q        <= v_d;
         index_q    <= index_d;
         row_base_q <= row_base_d;
         px_cnt_q   <= px_cnt_d;
         py_cnt_q   <= py_cnt_d;
         irq_q      <= irq_d;
         uo_q       <= uo_d;
         if (wr_any) begin
            case (address)
               6'h08: begin
                  line_cmp_q[7:0] <= data_in[7:0];
                  if (data_write_n != 2'b00) line_cmp_q[9:8] <= data_in[9:8];
               end
               6'h3C: begin
                  irq_type_q   <= data_in[1:0];
                  display_en_q <= data_in[2];
               end
               default: ;
            endcase
         end
         if (wr32) begin
            case (address)
               6'h10: for (int i = 0; i < 4; i++) pal_q[i] <= data_in[8*i +: 6];
               6'h14: stride_q <= data_in[9:0];
               6'h18: begin
                  pix_w_q <= data_in[6:0];
                  pix_h_q <= data_in[22:16];
               end
               6'h1C: start_q <= data_in[9:0];
               6'h20: vram_addr_q <= data_in[WAW-1:0];
               6'h24: vram_addr_q <= (vram_addr_q == WAW'(WORDS-1)) ? '0 : vram_addr_q + WAW'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr32 && (address == 6'h24)) vram_q[vram_addr_q] <= data_in;
   end

`ifdef VGA_CPU_STALL_EN
   logic stall_q;
   logic rd0;
   assign rd0 = (data_read_n != 2'b11) && (address == 6'h00);

   always_ff @(posedge clk) begin
      if (!rst_n)       stall_q <= 1'b0;
      else if (stall_q) begin
         if (h_q == H_VIS) stall_q <= 1'b0;
      end else if (rd0) stall_q <= 1'b1;
   end

   // The request cycle itself already reports not-ready; release happens on the h=1024 cycle.
   assign data_ready = stall_q ? (h_q == H_VIS) : !(rd0 && rst_n);
`else
   assign data_ready = 1'b1;
`endif

   assign data_out       = {16'd0, irq_q, 5'd0, v_q};
   assign user_interrupt = irq_q;
   assign uo_out         = uo_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, ui_in, data_read_n};

endmodule

// File: tb/tb_tqvp_rejunity_vga_scroll.sv
// Directed bench for the VGA scroller: pixel timing, VRAM wrap, scroll wrap, interrupts, optional CPU stall.
module tb_tqvp_rejunity_vga_scroll;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ui_in;
   logic [7:0]  uo_out;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   int cyc;
   int checks;
   int errors;

   typedef struct {
      int         c;
      logic [7:0] uo;
      logic       irq;
   } vec_t;

   vec_t tbl [11];

   always #5 clk = ~clk;

   tqvp_rejunity_vga_scroll dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ui_in          (ui_in),
      .uo_out         (uo_out),
      .address        (address),
      .data_in        (data_in),
      .data_write_n   (data_write_n),
      .data_read_n    (data_read_n),
      .data_out       (data_out),
      .data_ready     (data_ready),
      .user_interrupt (user_interrupt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
      end
   endtask

   task automatic wr_at(input int c, input logic [5:0] a, input logic [31:0] d, input logic [1:0] m);
      run_to(c);
      address      = a;
      data_in      = d;
      data_write_n = m;
      tick();
      data_write_n = 2'b11;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      cyc   = 0;
      chk("rst_uo", {24'd0, uo_out}, 32'h00);
      chk("rst_irq", {31'd0, user_interrupt}, 32'd0);
      chk("rst_ready", {31'd0, data_ready}, 32'd1);
      chk("rst_data_out", data_out, 32'h0000_0000);
   endtask

   initial begin
      cyc          = 0;
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      ui_in        = 8'd0;
      address      = 6'd0;
      data_in      = 32'd0;
      data_write_n = 2'b11;
      data_read_n  = 2'b11;

      // Line 1 replays pixel row 0: pixel 0 set (0x9B), others clear (0xA8); blanking 0x88, hsync 0x08.
      tbl = '{
         '{40,   8'hA8, 1'b0},
         '{1345, 8'h9B, 1'b0},
         '{1376, 8'h9B, 1'b0},
         '{1377, 8'hA8, 1'b0},
         '{2368, 8'hA8, 1'b0},
         '{2369, 8'h88, 1'b0},
         '{2392, 8'h88, 1'b0},
         '{2393, 8'h08, 1'b0},
         '{2528, 8'h08, 1'b0},
         '{2529, 8'h88, 1'b0},
         '{2688, 8'h88, 1'b0}
      };

      // Session 1: defaults, VRAM address wrap, palette, line-compare irq, display off.
      do_reset();
      wr_at(0, 6'h24, 32'h0000_0000, 2'b10);
      wr_at(1, 6'h20, 32'd31, 2'b10);
      wr_at(2, 6'h24, 32'h8000_0000, 2'b10);
      wr_at(3, 6'h24, 32'h0000_0001, 2'b10);
      wr_at(4, 6'h10, 32'h0000_0000, 2'b01);

      for (int i = 0; i < 11; i++) begin
         run_to(tbl[i].c);
         chk($sformatf("uo@%0d", tbl[i].c), {24'd0, uo_out}, {24'd0, tbl[i].uo});
         chk($sformatf("irq@%0d", tbl[i].c), {31'd0, user_interrupt}, {31'd0, tbl[i].irq});
      end

      wr_at(2700, 6'h08, 32'd3, 2'b10);
      wr_at(2701, 6'h3C, 32'h5, 2'b00);
      wr_at(2702, 6'h10, 32'h3F00_2A15, 2'b10);
      run_to(4033);
      chk("pal1_uo", {24'd0, uo_out}, 32'hDA);
      run_to(4065);
      chk("pal0_uo", {24'd0, uo_out}, 32'hAD);

      run_to(5056);
      chk("lcmp_irq_before", {31'd0, user_interrupt}, 32'd0);
      run_to(5057);
      chk("lcmp_irq_rise", {31'd0, user_interrupt}, 32'd1);
      run_to(5100);
      chk("read_status", data_out, 32'h0000_8003);
      run_to(5200);
      chk("irq_sticky", {31'd0, user_interrupt}, 32'd1);
      wr_at(5300, 6'h38, 32'd0, 2'b00);
      chk("irq_ack", {31'd0, user_interrupt}, 32'd0);

      wr_at(5310, 6'h08, 32'd4, 2'b01);
      run_to(6400);
      chk("setack_before", {31'd0, user_interrupt}, 32'd0);
      wr_at(6400, 6'h38, 32'd0, 2'b10);
      chk("set_wins", {31'd0, user_interrupt}, 32'd1);

      wr_at(6500, 6'h3C, 32'h3, 2'b10);
      run_to(6721);
      chk("dispoff_vis", {24'd0, uo_out}, 32'h88);
      run_to(7000);
      chk("irq_type3_hold", {31'd0, user_interrupt}, 32'd1);
      run_to(7769);
      chk("dispoff_hsync", {24'd0, uo_out}, 32'h08);
      run_to(7905);
      chk("dispoff_hsync_end", {24'd0, uo_out}, 32'h88);
      wr_at(8000, 6'h38, 32'd0, 2'b10);
      chk("irq_ack32", {31'd0, user_interrupt}, 32'd0);
      chk("read_v5", data_out, 32'h0000_0005);

      // Session 2: start=1000 with 1-line rows wraps row 1 to index 8; per-row irq; read of 0x00.
      do_reset();
      wr_at(0, 6'h18, 32'h0000_001F, 2'b10);
      wr_at(1, 6'h1C, 32'd1000, 2'b10);
      wr_at(2, 6'h20, 32'd31, 2'b10);
      wr_at(3, 6'h24, 32'h0000_0000, 2'b10);
      wr_at(4, 6'h24, 32'h0000_0100, 2'b10);
      wr_at(5, 6'h24, 32'h0000_0000, 2'b10);
      wr_at(6, 6'h3C, 32'h6, 2'b10);

      run_to(1024);
      chk("row_irq_before", {31'd0, user_interrupt}, 32'd0);
      run_to(1025);
      chk("row_irq_rise", {31'd0, user_interrupt}, 32'd1);
      run_to(1345);
      chk("wrap_idx8", {24'd0, uo_out}, 32'h9B);
      run_to(1377);
      chk("wrap_idx9", {24'd0, uo_out}, 32'hA8);

      run_to(2374);
      address     = 6'h00;
      data_read_n = 2'b10;
      #1;
`ifdef VGA_CPU_STALL_EN
      chk("stall_start", {31'd0, data_ready}, 32'd0);
      run_to(2375);
      chk("stall_hold", {31'd0, data_ready}, 32'd0);
      run_to(2689);
      chk("row2_idx40", {24'd0, uo_out}, 32'hA8);
      run_to(3711);
      chk("stall_last", {31'd0, data_ready}, 32'd0);
      run_to(3712);
      chk("stall_release", {31'd0, data_ready}, 32'd1);
      chk("stall_data", data_out, 32'h0000_8002);
      data_read_n = 2'b11;
      run_to(3800);
      data_read_n = 2'b10;
      #1;
      chk("stall2_start", {31'd0, data_ready}, 32'd0);
`else
      chk("read0_ready", {31'd0, data_ready}, 32'd1);
      chk("read0_data", data_out, 32'h0000_8001);
      data_read_n = 2'b11;
      run_to(2689);
      chk("row2_idx40", {24'd0, uo_out}, 32'hA8);
      run_to(3800);
      data_read_n = 2'b10;
      #1;
      chk("read0_ready2", {31'd0, data_ready}, 32'd1);
`endif
      run_to(3805);
      rst_n = 1'b0;
      tick();
      chk("rst_drops_stall", {31'd0, data_ready}, 32'd1);
      data_read_n = 2'b11;
      rst_n       = 1'b1;
      tick();
      chk("after_rst_ready", {31'd0, data_ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
